arb_2x32: RTL and testbench

ARB_2X32 -- requirements
Module: arb_2x32

---
 rtl/arb_pkg.sv | 24 ++
 rtl/mux_2x32.sv | 21 ++
 rtl/arb_2x32.sv | 102 ++++++++++
 tb/tb_arb_2x32.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared constants, state enum and helpers for the 2-way arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int C_DW    = 32;
    localparam int C_CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_2x32.sv
// ============================================================================
// Module : mux_2x32
// Brief  : Two-input data select (sel=0 -> a, sel=1 -> b).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2x32 #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sel,
    output logic [DW-1:0] out
);

    assign out = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/arb_2x32.sv
// ============================================================================
// Module : arb_2x32
// Brief  : Two-requester round-robin arbiter feeding a single output register.
//          Define ARB_2X32_GNT_CNT_EN to build the saturating grant counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_2x32
    import arb_pkg::*;
#(
    parameter int DW = C_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in0_valid,
    input  logic [DW-1:0]      in0_data,
    output logic               in0_ready,
    input  logic               in1_valid,
    input  logic [DW-1:0]      in1_data,
    output logic               in1_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic               out_src,
    input  logic               out_ready,
    output logic [C_CNT_W-1:0] gnt0_cnt,
    output logic [C_CNT_W-1:0] gnt1_cnt
);

    arb_state_e     r_state;
    logic [DW-1:0]  r_data;
    logic           r_src;
    logic           r_last;

    logic           w_load;
    logic           w_any;
    logic           w_gnt;
    logic           w_take;
    logic [DW-1:0]  w_sel_data;

    // Reset gates load so no beat is ever handshaken while rst is high.
    assign w_load = !rst && ((r_state == ST_EMPTY) || out_ready);
    assign w_any  = in0_valid || in1_valid;
    assign w_gnt  = (in0_valid && in1_valid) ? ~r_last : ~in0_valid;
    assign w_take = w_load && w_any;

    assign in0_ready = w_take && !w_gnt;
    assign in1_ready = w_take &&  w_gnt;

    mux_2x32 #(
        .DW (DW)
    ) u_mux (
        .a   (in0_data),
        .b   (in1_data),
        .sel (w_gnt),
        .out (w_sel_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_take) begin
            r_state <= ST_FULL;
            r_data  <= w_sel_data;
            r_src   <= w_gnt;
            r_last  <= w_gnt;
        end else if (w_load) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

`ifdef ARB_2X32_GNT_CNT_EN
    logic [C_CNT_W-1:0] r_gnt0_cnt;
    logic [C_CNT_W-1:0] r_gnt1_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else begin
            if (in0_ready) r_gnt0_cnt <= sat_inc(r_gnt0_cnt);
            if (in1_ready) r_gnt1_cnt <= sat_inc(r_gnt1_cnt);
        end
    end

    assign gnt0_cnt = r_gnt0_cnt;
    assign gnt1_cnt = r_gnt1_cnt;
`else
    assign gnt0_cnt = '0;
    assign gnt1_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_2x32.sv
// ============================================================================
// Module : tb_arb_2x32
// Brief  : Self-checking bench for arb_2x32 against a transaction-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_2x32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid;
    logic [31:0] in0_data, in1_data;
    logic        in0_ready, in1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready;
    logic [15:0] gnt0_cnt, gnt1_cnt;

    int total = 0;
    int bad   = 0;

    arb_2x32 #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .gnt0_cnt  (gnt0_cnt),
        .gnt1_cnt  (gnt1_cnt)
    );

    always #5 clk = ~clk;

    // Model: the held beat, who wins the next tie, and grant totals.
    bit          m_full;
    logic [31:0] m_data;
    bit          m_src;
    int          m_tie;
    int          m_c0, m_c1;
    bit          e_r0, e_r1;
    logic        a_r0, a_r1;

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef ARB_2X32_GNT_CNT_EN
        return (c > 65535) ? 16'hFFFF : c[15:0];
`else
        return (c >= 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic drive(input bit v0, input logic [31:0] d0, input bit v1,
                         input logic [31:0] d1, input bit ordy, input bit r);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy; rst = r;
    endtask

    // One clock: sample readies before the edge, advance model, settle after.
    task automatic tick;
        bit room;
        #2;
        a_r0 = in0_ready;
        a_r1 = in1_ready;
        room = !rst && (!m_full || out_ready);
        e_r0 = 0; e_r1 = 0;
        if (room) begin
            if (in0_valid && in1_valid) begin
                e_r0 = (m_tie == 0); e_r1 = (m_tie == 1);
            end else begin
                e_r0 = in0_valid; e_r1 = in1_valid;
            end
        end
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_data = 0; m_src = 0; m_tie = 0; m_c0 = 0; m_c1 = 0;
        end else if (e_r0 || e_r1) begin
            m_full = 1;
            m_data = e_r0 ? in0_data : in1_data;
            m_src  = e_r1;
            m_tie  = e_r0 ? 1 : 0;
            if (e_r0) m_c0++; else m_c1++;
        end else if (room) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic test_reset;
        drive(1, 32'h1234_5678, 1, 32'h8765_4321, 1, 1);
        tick();
        tick();
        total++; if (a_r0 !== 1'b0 || a_r1 !== 1'b0) begin bad++;
            $display("FAIL reset_ready got=%b%b want=00", a_r0, a_r1); end
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 1'b0) begin bad++;
            $display("FAIL reset_out got v=%b d=%h s=%b want v=0 d=0 s=0", out_valid, out_data, out_src); end
        total++; if (gnt0_cnt !== 16'h0 || gnt1_cnt !== 16'h0) begin bad++;
            $display("FAIL reset_cnt got=%h/%h want=0/0", gnt0_cnt, gnt1_cnt); end
    endtask

    task automatic test_single;
        drive(1, 32'hDEAD_BEEF, 0, 32'h0, 1, 0);
        tick();
        total++; if (a_r0 !== 1'b1 || a_r1 !== 1'b0) begin bad++;
            $display("FAIL single_ready got=%b%b want=10", a_r0, a_r1); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 1'b0) begin bad++;
            $display("FAIL single_out got v=%b d=%h s=%b want v=1 d=deadbeef s=0", out_valid, out_data, out_src); end
    endtask

    task automatic test_alternate;
        bit want_src;
        drive(0, 0, 0, 0, 1, 1);
        tick();
        drive(1, 32'h1111_1111, 1, 32'h2222_2222, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            want_src = i[0];
            total++; if (out_valid !== 1'b1 || out_src !== want_src ||
                         out_data !== (want_src ? 32'h2222_2222 : 32'h1111_1111)) begin bad++;
                $display("FAIL alternate[%0d] got v=%b s=%b d=%h want v=1 s=%b", i, out_valid, out_src, out_data, want_src); end
        end
    endtask

    task automatic test_backpressure;
        drive(1, 32'hA5A5_A5A5, 0, 0, 1, 0);
        tick();
        drive(0, 0, 1, 32'h5A5A_0001, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (a_r1 !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5) begin bad++;
                $display("FAIL stall[%0d] got rdy1=%b v=%b d=%h want rdy1=0 v=1 d=a5a5a5a5", i, a_r1, out_valid, out_data); end
        end
        drive(0, 0, 1, 32'h5A5A_0001, 1, 0);
        tick();
        total++; if (a_r1 !== 1'b1 || out_data !== 32'h5A5A_0001 || out_src !== 1'b1) begin bad++;
            $display("FAIL release got rdy1=%b d=%h s=%b want rdy1=1 d=5a5a0001 s=1", a_r1, out_data, out_src); end
    endtask

    task automatic test_drain;
        drive(1, 32'h0000_C0DE, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0000_C0DE) begin bad++;
            $display("FAIL drain got v=%b d=%h want v=0 d=0000c0de", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0000_C0DE) begin bad++;
            $display("FAIL idle_hold got v=%b d=%h want v=0 d=0000c0de", out_valid, out_data); end
    endtask

    task automatic test_reset_mid;
        drive(0, 0, 1, 32'h0BAD_F00D, 0, 0);
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D) begin bad++;
            $display("FAIL midrst_load got v=%b d=%h want v=1 d=0badf00d", out_valid, out_data); end
        drive(1, 32'h7777_7777, 1, 32'h8888_8888, 1, 1);
        tick();
        total++; if (a_r0 !== 1'b0 || a_r1 !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 ||
                     gnt0_cnt !== 16'h0 || gnt1_cnt !== 16'h0) begin bad++;
            $display("FAIL midrst got rdy=%b%b v=%b d=%h c=%h/%h want rdy=00 v=0 d=0 c=0/0",
                     a_r0, a_r1, out_valid, out_data, gnt0_cnt, gnt1_cnt); end
        drive(1, 32'h7777_7777, 1, 32'h8888_8888, 1, 0);
        tick();
        total++; if (a_r0 !== 1'b1 || a_r1 !== 1'b0 || out_src !== 1'b0 || out_data !== 32'h7777_7777) begin bad++;
            $display("FAIL post_rst_tie got rdy=%b%b s=%b d=%h want rdy=10 s=0 d=77777777", a_r0, a_r1, out_src, out_data); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), $urandom,
                  ($urandom_range(3, 0) != 0), ($urandom_range(63, 0) == 0));
            tick();
            total++; if (a_r0 !== e_r0 || a_r1 !== e_r1) begin bad++;
                $display("FAIL rand_ready[%0d] got=%b%b want=%b%b", i, a_r0, a_r1, e_r0, e_r1); end
            total++; if (out_valid !== m_full || out_data !== m_data || out_src !== m_src) begin bad++;
                $display("FAIL rand_out[%0d] got v=%b d=%h s=%b want v=%b d=%h s=%b",
                         i, out_valid, out_data, out_src, m_full, m_data, m_src); end
            total++; if (gnt0_cnt !== exp_cnt(m_c0) || gnt1_cnt !== exp_cnt(m_c1)) begin bad++;
                $display("FAIL rand_cnt[%0d] got=%h/%h want=%h/%h", i, gnt0_cnt, gnt1_cnt, exp_cnt(m_c0), exp_cnt(m_c1)); end
        end
    endtask

    task automatic test_counters;
        int n;
        drive(0, 0, 0, 0, 1, 1);
        tick();
`ifdef ARB_2X32_GNT_CNT_EN
        n = 70000;
`else
        n = 50;
`endif
        drive(1, 32'hC0C0_C0C0, 0, 0, 1, 0);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 65534) begin
                total++; if (gnt0_cnt !== exp_cnt(65535)) begin bad++;
                    $display("FAIL cnt_reach got=%h want=%h", gnt0_cnt, exp_cnt(65535)); end
            end
        end
        total++; if (gnt0_cnt !== exp_cnt(m_c0) || gnt1_cnt !== 16'h0) begin bad++;
            $display("FAIL cnt_sat got=%h/%h want=%h/0000", gnt0_cnt, gnt1_cnt, exp_cnt(m_c0)); end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 1);
        m_full = 0; m_data = 0; m_src = 0; m_tie = 0; m_c0 = 0; m_c1 = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
